// File: rtl/muldiv_pkg.sv
// Shared encodings and types for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam int MD_WIDTH = 32;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  // Per-operation control captured on the accepting edge.
  typedef struct packed {
    logic is_div;
    logic neg_res;
    logic neg_rem;
    logic div_zero;
  } md_flags_t;

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negate.
module muldiv_signfix #(
  parameter int W = 32
) (
  input  logic [W-1:0] in,
  input  logic         neg,
  output logic [W-1:0] out
);

  assign out = neg ? (~in + W'(1)) : in;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers: one result bit per
// cycle on magnitudes, sign correction in a final FIX cycle.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [WIDTH-1:0]   araw_q, araw_d;
  md_flags_t          flg_q, flg_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d;

  logic               sgn_op, sa, sb;
  logic [WIDTH-1:0]   a_mag, b_mag, quot_fix, rem_fix;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH:0]     mul_sum, div_tr;
  logic [2*WIDTH-1:0] mul_next, div_next;

  assign sgn_op = ~op[0];
  assign sa     = sgn_op & a[WIDTH-1];
  assign sb     = sgn_op & b[WIDTH-1];

  muldiv_signfix #(.W(WIDTH))   u_amag (.in(a), .neg(sa), .out(a_mag));
  muldiv_signfix #(.W(WIDTH))   u_bmag (.in(b), .neg(sb), .out(b_mag));
  muldiv_signfix #(.W(2*WIDTH)) u_prod (.in(acc_q), .neg(flg_q.neg_res), .out(prod_fix));
  muldiv_signfix #(.W(WIDTH))   u_quot (.in(acc_q[WIDTH-1:0]), .neg(flg_q.neg_res), .out(quot_fix));
  muldiv_signfix #(.W(WIDTH))   u_rem  (.in(acc_q[2*WIDTH-1:WIDTH]), .neg(flg_q.neg_rem), .out(rem_fix));

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, dvs_q};
  assign mul_next = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]}
                             : {1'b0, acc_q[2*WIDTH-1:1]};
  assign div_tr   = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, dvs_q};
  assign div_next = div_tr[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                  : {div_tr[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    dvs_d   = dvs_q;
    araw_d  = araw_q;
    flg_d   = flg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d        = ST_RUN;
          cnt_d          = CW'(WIDTH - 1);
          flg_d.is_div   = op[1];
          flg_d.neg_res  = sa ^ sb;
          flg_d.neg_rem  = sa;
          flg_d.div_zero = op[1] & (b == '0);
          acc_d          = {{WIDTH{1'b0}}, a_mag};
          dvs_d          = b_mag;
          araw_d         = a;
        end else begin
          if (hi_we) hi_d = wdata;
          if (lo_we) lo_d = wdata;
        end
      end
      ST_RUN: begin
        acc_d = flg_q.is_div ? div_next : mul_next;
        if (cnt_q == '0) state_d = ST_FIX;
        else             cnt_d   = cnt_q - CW'(1);
      end
      ST_FIX: begin
        if (flg_q.is_div) begin
          lo_d = flg_q.div_zero ? {WIDTH{1'b1}} : quot_fix;
          hi_d = flg_q.div_zero ? araw_q : rem_fix;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      dvs_q   <= '0;
      araw_q  <= '0;
      flg_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      dvs_q   <= dvs_d;
      araw_q  <= araw_d;
      flg_q   <= flg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected HI/LO, a monitor
// pops and compares on every done pulse.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0, b = '0, wdata = '0;
  logic        hi_we = 1'b0, lo_we = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual hi=%h lo=%h expected no pulse", hi, lo);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("result_hi_lo", {hi, lo}, e);
      end
    end
  end

  task automatic issue(input logic [1:0] o, input logic [31:0] aa, input logic [31:0] bb,
                       input logic [31:0] eh, input logic [31:0] el, input bit push);
    @(negedge clk);
    start = 1'b1; op = o; a = aa; b = bb;
    if (push) exp_q.push_back({eh, el});
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Waits for done (bounded), optionally checks busy length, then checks done falls.
  task automatic wait_done(input int exp_busy, input string nm);
    int nb;
    bit seen;
    nb = 0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else if (busy) nb++;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual no done expected done within 100 cycles", nm);
    end
    if (exp_busy > 0) chk({nm, "_busy_cycles"}, 64'(nb), 64'(exp_busy));
    @(negedge clk);
    chk({nm, "_done_pulse"}, {63'd0, done}, 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_state", {29'd0, busy, done, 1'b0, hi, lo}, 64'd0);

    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b1);
    wait_done(33, "multu_max");
    issue(2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b1);
    wait_done(33, "mult_neg");
    issue(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1);
    wait_done(33, "divu");
    issue(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1);
    wait_done(0, "div_neg");
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b1);
    wait_done(0, "div_ovf");
    issue(2'b11, 32'h0000_1234, 32'h0, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1);
    wait_done(0, "divu_zero");
    issue(2'b10, 32'hFFFF_FF00, 32'h0, 32'hFFFF_FF00, 32'hFFFF_FFFF, 1'b1);
    wait_done(0, "div_zero");

    // Idle MTHI, then simultaneous MTHI+MTLO.
    @(negedge clk);
    hi_we = 1'b1; wdata = 32'hA5A5_A5A5;
    @(negedge clk);
    hi_we = 1'b0;
    chk("mthi", {32'd0, hi}, {32'd0, 32'hA5A5_A5A5});
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h3C3C_3C3C;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    chk("mthi_mtlo", {hi, lo}, {32'h3C3C_3C3C, 32'h3C3C_3C3C});

    // Writes and a second start while busy are all ignored.
    issue(2'b01, 32'd3, 32'd5, 32'd0, 32'd15, 1'b1);
    repeat (3) @(negedge clk);
    start = 1'b1; op = 2'b11; a = 32'd9; b = 32'd3;
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    chk("busy_writes_ignored", {hi, lo}, {32'h3C3C_3C3C, 32'h3C3C_3C3C});
    wait_done(0, "busy_collide");

    // start beats lo_we in the same idle cycle.
    @(negedge clk);
    start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd7;
    lo_we = 1'b1; wdata = 32'h1111_1111;
    exp_q.push_back({32'd2, 32'd14});
    @(posedge clk);
    #1 start = 1'b0; lo_we = 1'b0;
    @(negedge clk);
    chk("start_beats_mtlo", {busy, 31'd0, lo}, {1'b1, 31'd0, 32'd15});
    wait_done(0, "start_mtlo");

    // Reset on the 10th RUN cycle abandons the operation.
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b0);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_reset", {29'd0, busy, done, 1'b0, hi, lo}, 64'd0);
    repeat (40) @(negedge clk);
    issue(2'b01, 32'd6, 32'd7, 32'd0, 32'd42, 1'b1);
    wait_done(33, "multu_after_reset");

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers. It sits directly downstream of the register file.
- It consumes the two register read ports (rs, rt values) for MULT, MULTU, DIV and DIVU, and serves MTHI/MTLO writes and MFHI/MFLO reads.
- It uses one result bit per cycle and signals completion to the pipeline-stall logic via busy/done.

Parameters:
- WIDTH, 32, operand width. HI and LO are each WIDTH bits.
- The iteration count equals WIDTH.
- Total latency is WIDTH+1 cycles.

Ports:
- clk  input  1  clock; all state changes on the rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request a multiply/divide; sampled only when busy=0
- op  input  2  operation, sampled with start: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- a  input  WIDTH  rs operand (multiplicand / dividend)
- b  input  WIDTH  rt operand (multiplier / divisor)
- hi_we  input  1  MTHI write strobe
- lo_we  input  1  MTLO write strobe
- wdata  input  WIDTH  MTHI/MTLO data
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse when a new HI/LO result is committed
- hi  output  WIDTH  HI register (MFHI source)
- lo  output  WIDTH  LO register (MFLO source)

Behaviour:
- Reset:
  - Applies on the clock edge where rst=1.
  - State goes to IDLE; hi=0, lo=0, busy=0, done=0; counter and working registers cleared.
  - Reset mid-operation abandons the operation; no partial HI/LO write occurs.
- States: IDLE, RUN, FIX.
- IDLE:
  - start=1 moves to RUN.
  - On the same edge, latch op and compute operand magnitudes (for signed ops: |a|, |b|, result-sign flags).
  - Load counter = WIDTH-1.
  - busy=1 from the next cycle.
- RUN:
  - Multiply: one shift-add step per cycle on a 2*WIDTH unsigned accumulator.
  - Divide: one restoring shift-subtract step per cycle, producing a WIDTH-bit quotient and a WIDTH-bit remainder.
  - The counter decrements each cycle; after WIDTH cycles in RUN, move to FIX.
- FIX (one cycle):
  - Apply sign correction.
  - Signed multiply: negate the 2*WIDTH product if the operand signs differ.
  - Signed divide:
    - Negate the quotient if the operand signs differ.
    - Negate the remainder if the dividend is negative, so the remainder takes the dividend's sign.
  - The edge leaving FIX writes the results:
    - Multiply: hi = product high half, lo = product low half.
    - Divide: lo = quotient, hi = remainder.
  - On that edge busy=0 and done=1; then return to IDLE.
- Timing: busy is high for exactly WIDTH+1 cycles. The new hi/lo values are visible in the same cycle as the done pulse. done deasserts on the following cycle.
- Divide by zero (b=0), DIV or DIVU: lo=all ones, hi=a (raw operand), forced in FIX.
- Signed overflow (a=0x80000000, b=0xFFFFFFFF, DIV): lo=0x80000000, hi=0. This falls out of the magnitude arithmetic; no special case is needed.
- MTHI/MTLO:
  - When busy=0, hi_we writes hi and lo_we writes lo on the next edge.
  - Both may assert in the same cycle; both registers are then written with wdata.
  - Ignored while busy=1.
- Collisions:
  - start and hi_we/lo_we in the same idle cycle: start wins and the writes are dropped.
  - start while busy=1 is ignored; no queueing.
- Operands a, b and op are ignored except on the accepting edge; they may change freely during RUN.
- hi/lo hold their values in all states except the commit edge, an MTHI/MTLO write, or reset.

Decomposition:
- Shared package:
  - Op encodings MD_MULT=2'b00, MD_MULTU=2'b01, MD_DIV=2'b10, MD_DIVU=2'b11.
  - State encoding IDLE/RUN/FIX.
  - Default WIDTH.
- One natural combinational sub-module, muldiv_signfix:
  - Conditional two's-complement negate, parameterised by width.
  - Instantiated for operand magnitudes at accept and for product/quotient/remainder correction in FIX.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> busy high 33 cycles; done single pulse; hi=0xFFFFFFFE, lo=0x00000001 in the done cycle.
- MULT a=0xFFFFFFFD (-3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then DIVU a=100, b=7 -> lo=0x0000000E, hi=0x00000002.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=0x1234, b=0 -> lo=0xFFFFFFFF, hi=0x00001234. DIV a=0xFFFFFF00, b=0 -> lo=0xFFFFFFFF, hi=0xFFFFFF00.
- Idle: hi_we with wdata=0xA5A5A5A5 -> hi=0xA5A5A5A5 next cycle. During busy: hi_we, lo_we and a second start are all ignored, and the first result is committed unaltered. start and lo_we in the same idle cycle -> lo is not written from wdata.
- rst asserted on the 10th RUN cycle -> next cycle busy=0, done=0, hi=lo=0, with no done pulse later. A fresh MULTU 6*7 then gives lo=42, hi=0 after 33 cycles.
